addr_reg_arbiter: RTL and testbench

ADDR_REG_ARBITER -- requirements
Module: addr_reg_arbiter

---
 rtl/addr_reg_arbiter.sv | 128 ++++++++++++
 tb/tb_addr_reg_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_reg_arbiter.sv
// Two-requester arbiter in front of a shared 16-bit register, with optional lock
// (exclusive ownership) bounded by LOCK_MAX cycles and registered register drive.
module addr_reg_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        cmd0,
  input  logic        cmd1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        reg_write_en,
  output logic        reg_inc,
  output logic [15:0] reg_datain,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  state_t     state;
  logic [7:0] lock_cnt;
  logic       prio;      // 0: requester 0 wins a tie, 1: requester 1 wins
  logic       xfer0;
  logic       xfer1;

  // Handshake: reqN is the valid, gntN the ready; a transfer happens on any
  // cycle where both are high, and no state is held for an ungranted request.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = !prio;
            gnt1 = prio;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign xfer0 = req0 && gnt0;
  assign xfer1 = req1 && gnt1;
  assign owner = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lock_cnt     <= 8'd0;
      prio         <= 1'b0;
      reg_write_en <= 1'b0;
      reg_inc      <= 1'b0;
      reg_datain   <= 16'h0000;
    end else begin
      reg_inc      <= (xfer0 && !cmd0) || (xfer1 && !cmd1);
      reg_write_en <= (xfer0 && cmd0) || (xfer1 && cmd1);
      if (xfer0 && cmd0) begin
        reg_datain <= data0;
      end else if (xfer1 && cmd1) begin
        reg_datain <= data1;
      end

      if (xfer0) begin
        prio <= 1'b1;
      end else if (xfer1) begin
        prio <= 1'b0;
      end

      // Timeout takes precedence over a still-held lock and hands the next tie away.
      case (state)
        IDLE: begin
          lock_cnt <= 8'd0;
          if (xfer0 && lock0) begin
            state <= OWN0;
          end else if (xfer1 && lock1) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          lock_cnt <= lock_cnt + 8'd1;
          if (lock_cnt == LOCK_LAST) begin
            state    <= IDLE;
            prio     <= 1'b1;
            lock_cnt <= 8'd0;
          end else if (!lock0) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end
        end
        OWN1: begin
          lock_cnt <= lock_cnt + 8'd1;
          if (lock_cnt == LOCK_LAST) begin
            state    <= IDLE;
            prio     <= 1'b0;
            lock_cnt <= 8'd0;
          end else if (!lock1) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_reg_arbiter.sv
// Bench for addr_reg_arbiter: cycle-level model of ownership/tie rules with a load
// scoreboard, plus literal checks on a LOCK_MAX=4 instance for the timeout case.
module tb_addr_reg_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk;
  logic        rst;
  logic        req0, req1, cmd0, cmd1, lock0, lock1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, reg_write_en, reg_inc;
  logic [15:0] reg_datain;
  logic [1:0]  owner;
  logic        t_gnt0, t_gnt1, t_write_en, t_inc;
  logic [15:0] t_datain;
  logic [1:0]  t_owner;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];

  addr_reg_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .data0(data0), .data1(data1), .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .reg_write_en(reg_write_en), .reg_inc(reg_inc),
    .reg_datain(reg_datain), .owner(owner)
  );

  addr_reg_arbiter #(.LOCK_MAX(4)) dut_t (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .data0(data0), .data1(data1), .lock0(lock0), .lock1(lock1),
    .gnt0(t_gnt0), .gnt1(t_gnt1), .reg_write_en(t_write_en), .reg_inc(t_inc),
    .reg_datain(t_datain), .owner(t_owner)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: who owns, for how many cycles, who wins the next tie, expected drive
  int          m_own;
  int          m_age;
  int          m_favour;
  logic        m_we, m_inc;
  logic [15:0] m_data;

  function automatic int m_grant();
    if (rst) return -1;
    if (m_own == 0) return req0 ? 0 : -1;
    if (m_own == 1) return req1 ? 1 : -1;
    if (req0 && req1) return m_favour;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    int          g;
    logic        c, l, own_lock;
    logic [15:0] d;
    if (rst) begin
      m_own = -1; m_age = 0; m_favour = 0;
      m_we = 1'b0; m_inc = 1'b0; m_data = 16'h0000;
      exp_q.delete();
    end else begin
      g = m_grant();
      c = (g == 1) ? cmd1 : cmd0;
      l = (g == 1) ? lock1 : lock0;
      d = (g == 1) ? data1 : data0;
      m_we  = (g >= 0) && c;
      m_inc = (g >= 0) && !c;
      if (m_we) begin
        m_data = d;
        exp_q.push_back(d);
      end
      if (g >= 0) m_favour = 1 - g;
      own_lock = (m_own == 1) ? lock1 : lock0;
      if (m_own < 0) begin
        if (g >= 0 && l) begin
          m_own = g;
          m_age = 1;
        end
      end else if (m_age == LOCK_MAX) begin
        m_favour = 1 - m_own;
        m_own = -1;
      end else if (!own_lock) begin
        m_own = -1;
      end else begin
        m_age++;
      end
    end
  end

  // scoreboard: every cycle, outputs against the model
  always @(negedge clk) begin : compare
    int          g;
    logic [15:0] e;
    g = m_grant();
    chk("gnt0", gnt0, g == 0);
    chk("gnt1", gnt1, g == 1);
    chk("owner", owner, (m_own < 0) ? 0 : ((m_own == 0) ? 1 : 2));
    chk("reg_write_en", reg_write_en, m_we);
    chk("reg_inc", reg_inc, m_inc);
    chk("reg_datain", reg_datain, m_data);
    if (reg_write_en === 1'b1) begin
      chk("load_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("load_order", reg_datain, e);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r0, input logic c0, input logic l0, input logic [15:0] d0,
                     input logic r1, input logic c1, input logic l1, input logic [15:0] d1);
    req0 = r0; cmd0 = c0; lock0 = l0; data0 = d0;
    req1 = r1; cmd1 = c1; lock1 = l1; data1 = d1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    tick(); tick();

    // command presented during reset is dropped
    set(1, 1, 0, 16'hDEAD, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_owner", owner, 0);
    chk("rst_datain", reg_datain, 16'h0000);
    tick();
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_discard_we", reg_write_en, 0);
    tick();

    // single increment
    set(1, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    @(negedge clk); chk("inc_gnt0", gnt0, 1);
    tick();
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    @(negedge clk); chk("inc_pulse", reg_inc, 1); chk("inc_no_we", reg_write_en, 0);
    tick();
    @(negedge clk); chk("inc_once", reg_inc, 0);
    tick();

    // tie after reset, back-to-back loads
    rst_pulse();
    set(1, 1, 0, 16'h1234, 1, 1, 0, 16'hABCD);
    @(negedge clk); chk("tie_gnt0", gnt0, 1); chk("tie_gnt1_lo", gnt1, 0);
    tick();
    req0 = 1'b0;
    @(negedge clk); chk("tie_gnt1", gnt1, 1); chk("tie_we1", reg_write_en, 1);
    chk("tie_data1", reg_datain, 16'h1234);
    tick();
    req1 = 1'b0;
    @(negedge clk); chk("tie_we2", reg_write_en, 1); chk("tie_data2", reg_datain, 16'hABCD);
    tick();
    @(negedge clk); chk("tie_we_off", reg_write_en, 0); chk("tie_hold", reg_datain, 16'hABCD);
    tick();

    // lock hold by requester 0
    set(1, 0, 1, 16'h0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lock_gnt1_lo", gnt1, 0);
      if (i > 0) chk("lock_owner", owner, 2'b01);
      tick();
    end
    req0 = 1'b0; lock0 = 1'b0;
    @(negedge clk); chk("unlock_gnt1_lo", gnt1, 0);
    tick();
    @(negedge clk); chk("unlock_owner", owner, 2'b00); chk("unlock_gnt1", gnt1, 1);
    tick();
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    tick();

    // timeout on the LOCK_MAX=4 instance; main instance runs to its own timeout
    rst_pulse();
    set(1, 0, 1, 16'h0, 1, 0, 0, 16'h0);
    @(negedge clk); chk("to_gnt0", t_gnt0, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_owner", t_owner, 2'b01);
      chk("to_gnt1_lo", t_gnt1, 0);
      tick();
    end
    @(negedge clk);
    chk("to_idle", t_owner, 2'b00);
    chk("to_gnt1", t_gnt1, 1);
    chk("to_gnt0_lo", t_gnt0, 0);
    tick();
    repeat (20) tick();
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    tick(); tick();

    // mixed vectors: requester 1 lock, idle lock drop, ties, wrap value
    rst_pulse();
    set(0, 0, 0, 16'h0,    1, 1, 1, 16'h0F0F); tick();
    set(1, 1, 0, 16'h1111, 1, 0, 1, 16'h0);    tick();
    set(1, 1, 0, 16'h1111, 0, 0, 1, 16'h0);    tick();
    set(1, 1, 0, 16'h2222, 0, 0, 0, 16'h0);    tick();
    set(1, 1, 0, 16'h3333, 1, 1, 0, 16'h4444); tick();
    set(1, 1, 0, 16'h3333, 1, 1, 0, 16'h4444); tick();
    set(1, 0, 1, 16'h0,    0, 0, 0, 16'h0);    tick();
    set(1, 1, 0, 16'hFFFF, 0, 0, 0, 16'h0);    tick();
    set(0, 0, 0, 16'h0,    0, 0, 0, 16'h0);    tick(); tick();

    // asynchronous reset while requester 1 owns and a load pulse is out
    rst_pulse();
    set(0, 0, 0, 16'h0, 1, 1, 1, 16'h5A5A);
    tick();
    #2;
    chk("async_pre_we", reg_write_en, 1);
    chk("async_pre_owner", owner, 2'b10);
    rst = 1'b1;
    #1;
    chk("async_we", reg_write_en, 0);
    chk("async_datain", reg_datain, 16'h0000);
    chk("async_owner", owner, 2'b00);
    chk("async_gnt0", gnt0, 0);
    chk("async_gnt1", gnt1, 0);
    tick();
    @(negedge clk); chk("async_hold_gnt1", gnt1, 0);
    set(0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    rst = 1'b0;
    tick(); tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
